mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter AW, default 16: address width.
REQ-002 SHALL have parameter DW, default 16: data width.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 SHALL have port i_req  input  1: fetch requester read request.
REQ-006 SHALL have port i_addr  input  AW: fetch address.
REQ-007 SHALL have port i_ack  output  1: fetch completion pulse.
REQ-008 SHALL have port d_req  input  1: data requester request.
REQ-009 SHALL have port d_we  input  1: data requester write (1) or read (0).
REQ-010 SHALL have port d_addr  input  AW: data address.
REQ-011 SHALL have port d_wdata  input  DW: data write value.
REQ-012 SHALL have port d_ack  output  1: data completion pulse.
REQ-013 SHALL have port rdata  output  DW: read result, shared by both requesters.
REQ-014 SHALL have port ram_addr  output  AW: address to RAM.
REQ-015 SHALL have port ram_we  output  1: RAM write strobe.
REQ-016 SHALL have port ram_din  output  DW: RAM write data.
REQ-017 SHALL have port ram_dout  input  DW: RAM read data, combinational from ram_addr.

Function
REQ-018 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-019 In IDLE with any request, SHALL latch winner, address, we and wdata, then go to ACCESS; otherwise SHALL stay in IDLE.
REQ-020 Arbitration SHALL be fixed priority: data over fetch when both requests are present.
REQ-021 In ACCESS, SHALL drive ram_addr from the latched address, assert ram_we only for a latched write, capture ram_dout into rdata on reads, then go to RESP.
REQ-022 In RESP, SHALL pulse the winner's ack for exactly one cycle.
REQ-023 In RESP, SHALL mask the just-acked requester's req; if the other requester's req is high, SHALL latch it and go to ACCESS; otherwise SHALL go to IDLE.
REQ-024 Latency SHALL be 2 cycles from req sampled in IDLE to ack; back-to-back throughput SHALL be 1 access per 2 cycles.
REQ-025 Requesters SHALL hold req, addr, we and wdata stable until ack; the arbiter uses only latched values after grant.
REQ-026 A write SHALL leave rdata unchanged.
REQ-027 When not in ACCESS, ram_we SHALL be 0 and ram_addr SHALL hold the last latched address.
REQ-028 i_ack and d_ack SHALL never be high in the same cycle.

Reset
REQ-029 On rst_n low, SHALL immediately force state IDLE; i_ack, d_ack and ram_we SHALL be 0; rdata, ram_addr and ram_din SHALL be 0.
REQ-030 An access in progress SHALL be abandoned with no ack; after reset release the requester re-arbitrates normally.

Configuration
REQ-031 SHALL support macro MEM_ARB_WR_EN.
REQ-032 With MEM_ARB_WR_EN defined, d_we writes are performed as specified.
REQ-033 Without MEM_ARB_WR_EN: d_we is ignored, every data access is a read, ram_we is tied 0 and ram_din is tied 0.

Structure
REQ-034 The shared package mem_arb_pkg SHALL hold the FSM state enum, the winner encoding (WIN_I, WIN_D) and the default AW/DW constants.
REQ-035 No sub-module is needed; arbitration SHALL be inline in mem_arb.

Verification
REQ-036 Bench RAM is preloaded with 0x0000=0xA861, 0x0001=0x8463 and all others 0.
REQ-037 Scenario: i_req with i_addr=0x0000 from IDLE -> ram_addr=0x0000 at cycle 1; i_ack and rdata=0xA861 at cycle 2.
REQ-038 Scenario: i_req(0x0001) and d_req(0x0000, read) in the same cycle -> d_ack with rdata=0xA861 first; then i_ack with rdata=0x8463 two cycles later, with no IDLE gap.
REQ-039 Scenario (WR_EN): d_we=1, d_addr=0x0005, d_wdata=0x1234 -> ram_we high for one cycle with ram_din=0x1234; rdata unchanged. A subsequent read of 0x0005 -> 0x1234.
REQ-040 Scenario (no WR_EN): same write stimulus -> ram_we stays 0; d_ack occurs with rdata=0x0000.
REQ-041 Scenario: rst_n asserted during ACCESS -> no ack; all outputs 0 immediately; after release a held i_req completes in 2 cycles.
REQ-042 Scenario: i_req and d_req held high continuously -> acks alternate D, I, D, I, each 2 cycles apart, never coincident.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM state codes,
// winner encoding and default bus widths.
package mem_arb_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;

  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t ACCESS = 2'd1;
  localparam state_t RESP   = 2'd2;

  typedef logic win_t;
  localparam win_t WIN_I = 1'b0;
  localparam win_t WIN_D = 1'b1;

endpackage

// File: rtl/mem_arb.sv
// Fixed-priority (data over fetch) arbiter sharing one combinational-read RAM.
// Define MEM_ARB_WR_EN to enable data-side writes; otherwise every access is a read.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  state_t        state_q, state_d;
  win_t          win_q, grant_win;
  logic          grant;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] rdata_q;
  logic          we_q;

  // In RESP the just-acked requester is masked so the other side gets the next slot.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant     = 1'b0;
    grant_win = WIN_I;
    state_d   = IDLE;
    case (state_q)
      IDLE: begin
        if (d_req) begin
          grant     = 1'b1;
          grant_win = WIN_D;
        end else if (i_req) begin
          grant     = 1'b1;
          grant_win = WIN_I;
        end
        state_d = grant ? ACCESS : IDLE;
      end
      ACCESS: state_d = RESP;
      RESP: begin
        if (win_q == WIN_I && d_req) begin
          grant     = 1'b1;
          grant_win = WIN_D;
        end else if (win_q == WIN_D && i_req) begin
          grant     = 1'b1;
          grant_win = WIN_I;
        end
        state_d = grant ? ACCESS : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q   <= WIN_I;
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        win_q  <= grant_win;
        addr_q <= (grant_win == WIN_D) ? d_addr : i_addr;
      end
      if (state_q == ACCESS && !we_q) rdata_q <= ram_dout;
    end
  end

`ifdef MEM_ARB_WR_EN
  logic [DW-1:0] wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (grant) begin
      we_q    <= (grant_win == WIN_D) && d_we;
      wdata_q <= (grant_win == WIN_D) ? d_wdata : '0;
    end
  end

  assign ram_din = wdata_q;
`else
  logic unused_wr;

  assign we_q      = 1'b0;
  assign ram_din   = '0;
  assign unused_wr = ^{d_we, d_wdata};
`endif

  assign ram_addr = addr_q;
  assign ram_we   = (state_q == ACCESS) && we_q;
  assign rdata    = rdata_q;
  assign i_ack    = (state_q == RESP) && (win_q == WIN_I);
  assign d_ack    = (state_q == RESP) && (win_q == WIN_D);

endmodule

// File: tb/tb_mem_arb.sv
// Directed self-checking bench for mem_arb with a combinational-read RAM model.
// Expected values follow MEM_ARB_WR_EN when the bench is built with it.
module tb_mem_arb;

  localparam int AW = 16;
  localparam int DW = 16;

`ifdef MEM_ARB_WR_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          i_ack, d_ack, ram_we;
  logic [DW-1:0] rdata, ram_din, ram_dout;
  logic [AW-1:0] ram_addr;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arb #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_ack    (i_ack),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ack    (d_ack),
    .rdata    (rdata),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  assign ram_dout = mem[ram_addr];

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Advance to the next falling edge, where outputs are stable.
  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a falling edge; the request is seen by the arbiter at the next rising edge.
  task automatic start_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_ack [1:8];
  logic [DW-1:0] rdata_before;

  initial begin
    for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
    mem[16'h0000] = 16'hA861;
    mem[16'h0001] = 16'h8463;

    rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_i_ack", i_ack, 0);
    check("rst_d_ack", d_ack, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_rdata", rdata, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_din", ram_din, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single fetch from IDLE: address at cycle 1, ack at cycle 2.
    start_cycle();
    i_req = 1'b1; i_addr = 16'h0000;
    next_cycle();
    check("f1_ram_addr", ram_addr, 16'h0000);
    check("f1_no_ack_c1", {d_ack, i_ack}, 2'b00);
    next_cycle();
    check("f1_i_ack", {d_ack, i_ack}, 2'b01);
    check("f1_rdata", rdata, 16'hA861);
    i_req = 1'b0;
    next_cycle();
    check("f1_ack_pulse", {d_ack, i_ack}, 2'b00);

    // Simultaneous requests: data first, fetch follows with no IDLE gap.
    i_req = 1'b1; i_addr = 16'h0001;
    d_req = 1'b1; d_addr = 16'h0000; d_we = 1'b0;
    next_cycle();
    check("pr_ram_addr_d", ram_addr, 16'h0000);
    next_cycle();
    check("pr_d_ack", {d_ack, i_ack}, 2'b10);
    check("pr_d_rdata", rdata, 16'hA861);
    d_req = 1'b0;
    next_cycle();
    check("pr_ram_addr_i", ram_addr, 16'h0001);
    check("pr_no_ack_c3", {d_ack, i_ack}, 2'b00);
    next_cycle();
    check("pr_i_ack", {d_ack, i_ack}, 2'b01);
    check("pr_i_rdata", rdata, 16'h8463);
    i_req = 1'b0;
    next_cycle();

    // Data write to 0x0005, then read it back.
    rdata_before = rdata;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0005; d_wdata = 16'h1234;
    next_cycle();
    check("wr_ram_addr", ram_addr, 16'h0005);
    check("wr_ram_we", ram_we, WR_EN ? 1 : 0);
    check("wr_ram_din", ram_din, WR_EN ? 16'h1234 : 16'h0000);
    next_cycle();
    check("wr_d_ack", {d_ack, i_ack}, 2'b10);
    check("wr_ram_we_off", ram_we, 0);
    check("wr_rdata", rdata, WR_EN ? rdata_before : 16'h0000);
    d_req = 1'b0; d_we = 1'b0;
    next_cycle();
    d_req = 1'b1; d_addr = 16'h0005;
    next_cycle();
    check("rb_ram_we", ram_we, 0);
    next_cycle();
    check("rb_d_ack", {d_ack, i_ack}, 2'b10);
    check("rb_rdata", rdata, WR_EN ? 16'h1234 : 16'h0000);
    d_req = 1'b0;
    next_cycle();

    // Reset during ACCESS abandons the fetch; a held request then completes normally.
    i_req = 1'b1; i_addr = 16'h0001;
    next_cycle();
    check("rs_in_access", ram_addr, 16'h0001);
    rst_n = 1'b0;
    #1;
    check("rs_ram_addr", ram_addr, 0);
    check("rs_rdata", rdata, 0);
    check("rs_ram_we", ram_we, 0);
    check("rs_ram_din", ram_din, 0);
    check("rs_acks", {d_ack, i_ack}, 2'b00);
    next_cycle();
    check("rs_hold_no_ack", {d_ack, i_ack}, 2'b00);
    rst_n = 1'b1;
    next_cycle();
    check("rs_re_addr", ram_addr, 16'h0001);
    check("rs_re_no_ack", {d_ack, i_ack}, 2'b00);
    next_cycle();
    check("rs_re_i_ack", {d_ack, i_ack}, 2'b01);
    check("rs_re_rdata", rdata, 16'h8463);
    i_req = 1'b0;
    next_cycle();

    // Both requesters held: acks alternate D, I, D, I two cycles apart.
    for (int c = 1; c <= 8; c++) exp_ack[c] = 2'b00;
    exp_ack[2] = 2'b10; exp_ack[4] = 2'b01; exp_ack[6] = 2'b10; exp_ack[8] = 2'b01;
    i_req = 1'b1; i_addr = 16'h0000;
    d_req = 1'b1; d_addr = 16'h0001; d_we = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      next_cycle();
      check($sformatf("alt_ack_c%0d", c), {d_ack, i_ack}, exp_ack[c]);
      if (exp_ack[c] == 2'b10) check($sformatf("alt_d_rdata_c%0d", c), rdata, 16'h8463);
      if (exp_ack[c] == 2'b01) check($sformatf("alt_i_rdata_c%0d", c), rdata, 16'hA861);
    end
    i_req = 1'b0; d_req = 1'b0;
    next_cycle();
    check("alt_idle_after", {d_ack, i_ack}, 2'b00);
    next_cycle();
    check("alt_idle_we", ram_we, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
